// File: rtl/lsu_mem_master.sv
// Byte-addressed RISC-V load/store unit driving a word-only data memory.
// Sub-word loads are extracted and extended; sub-word stores use read-modify-write.
module lsu_mem_master #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [31:0]       mem_rdata
);

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      r_state;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [1:0]  r_lane;
   logic [15:0] r_wdata;

   logic        w_err;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merged;
   logic        w_unused_addr;

   // Address bits above the word index wrap and are intentionally ignored.
   assign w_unused_addr = ^req_addr[31:ADDR_W+2];
   assign req_ready     = (r_state == IDLE);

   always_comb begin
      case (req_funct3)
         F_B:       w_err = 1'b0;
         F_H:       w_err = req_addr[0];
         F_W:       w_err = (req_addr[1:0] != 2'b00);
         F_BU, F_HU: w_err = req_we;
         default:   w_err = 1'b1;
      endcase
   end

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      w_byte   = mem_rdata[{r_lane, 3'b000} +: 8];
      w_half   = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      w_merged = mem_rdata;
      case (r_funct3)
         F_B:     w_load = {{24{w_byte[7]}}, w_byte};
         F_BU:    w_load = {24'h0, w_byte};
         F_H:     w_load = {{16{w_half[15]}}, w_half};
         F_HU:    w_load = {16'h0, w_half};
         default: w_load = mem_rdata;
      endcase
      if (r_funct3 == F_B)
         w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      else
         w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_we       <= 1'b0;
         r_funct3   <= 3'b000;
         r_lane     <= 2'b00;
         r_wdata    <= 16'h0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= 32'h0;
      end else begin
         // NOTE: non-blocking defaults make strobes and resp_valid single-cycle pulses.
         resp_valid <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_funct3 <= req_funct3;
                  r_lane   <= req_addr[1:0];
                  r_wdata  <= req_wdata[15:0];
                  mem_addr <= req_addr[ADDR_W+1:2];
                  if (w_err) begin
                     r_state    <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                  end else if (req_we && req_funct3 == F_W) begin
                     r_state   <= WRITE;
                     mem_write <= 1'b1;
                     mem_wdata <= req_wdata;
                  end else begin
                     r_state  <= READ;
                     mem_read <= 1'b1;
                  end
               end
            end
            READ: begin
               if (r_we) begin
                  r_state   <= WRITE;
                  mem_write <= 1'b1;
                  mem_wdata <= w_merged;
               end else begin
                  r_state    <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= w_load;
               end
            end
            WRITE: begin
               r_state    <= RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= 32'h0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed requests push expectations,
// a negedge monitor checks strobes and responses against them.
module tb_lsu_mem_master;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_write, mem_read;

   logic [31:0] mem [64];

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          n_rd;
      int          n_wr;
      logic [5:0]  addr;
      logic [31:0] wdata;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   rd_seen = 0;
   int   wr_seen = 0;

   lsu_mem_master #(.ADDR_W(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_read(mem_read), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign mem_rdata = mem_read ? mem[mem_addr] : 32'h0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_write) mem[mem_addr] <= mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: strobe legality per cycle, response comparison on resp_valid.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_read && mem_write) check("strobe_exclusive", 32'(mem_read & mem_write), 32'd0);
         if (mem_read || mem_write) begin
            if (exp_q.size() == 0) check("spurious_strobe", 32'd1, 32'd0);
            else begin
               check("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
               if (mem_write) check("mem_wdata", mem_wdata, exp_q[0].wdata);
            end
            if (mem_read)  rd_seen++;
            if (mem_write) wr_seen++;
         end
         if (resp_valid) begin
            if (exp_q.size() == 0) check("spurious_resp", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               check("resp_err",   32'(resp_err), 32'(e.err));
               check("resp_rdata", resp_rdata, e.rdata);
               check("latency",    32'(cyc - e.acc), 32'(e.lat));
               check("read_count", 32'(rd_seen), 32'(e.n_rd));
               check("write_count", 32'(wr_seen), 32'(e.n_wr));
               check("ready_in_resp", 32'(req_ready), 32'd0);
            end
            rd_seen = 0;
            wr_seen = 0;
         end
      end
   end

   // Called at a negedge; holds req_valid high and returns at the negedge after accept.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                        input int lat, input int n_rd, input int n_wr,
                        input logic [31:0] wexp, output int waited, output int acc);
      exp_t e;
      waited     = 0;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      acc = cyc;
      if (!req_ready) begin
         check("accept_timeout", 32'd1, 32'd0);
         return;
      end
      e.err = err; e.rdata = rdata; e.lat = lat; e.n_rd = n_rd; e.n_wr = n_wr;
      e.addr = addr[7:2]; e.wdata = wexp; e.acc = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      req_we     = 1'bx;
      req_funct3 = 3'bxxx;
      req_addr   = 32'hxxxx_xxxx;
      req_wdata  = 32'hxxxx_xxxx;
   endtask

   task automatic drain();
      int n;
      n = 0;
      req_valid = 1'b0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic go(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                     input int lat, input int n_rd, input int n_wr, input logic [31:0] wexp);
      int w, a;
      issue(we, f3, addr, wdata, err, rdata, lat, n_rd, n_wr, wexp, w, a);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w1, a1, w2, a2;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // SW then sub-word loads of 0xDEADBEEF at word 4
      go(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2, 0, 1, 32'hDEADBEEF);
      check("mem4_after_sw", mem[4], 32'hDEADBEEF);
      go(0, 3'b000, 32'h11, 32'h0, 0, 32'hFFFFFFBE, 2, 1, 0, 32'h0);
      go(0, 3'b100, 32'h11, 32'h0, 0, 32'h000000BE, 2, 1, 0, 32'h0);
      go(0, 3'b001, 32'h12, 32'h0, 0, 32'hFFFFDEAD, 2, 1, 0, 32'h0);
      go(0, 3'b101, 32'h12, 32'h0, 0, 32'h0000DEAD, 2, 1, 0, 32'h0);
      go(0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 2, 1, 0, 32'h0);

      // Read-modify-write stores
      go(1, 3'b000, 32'h13, 32'h12345677, 0, 32'h0, 3, 1, 1, 32'h77ADBEEF);
      go(0, 3'b010, 32'h10, 32'h0, 0, 32'h77ADBEEF, 2, 1, 0, 32'h0);
      go(1, 3'b001, 32'h12, 32'hAAAA1234, 0, 32'h0, 3, 1, 1, 32'h1234BEEF);
      go(0, 3'b001, 32'h12, 32'h0, 0, 32'h00001234, 2, 1, 0, 32'h0);
      go(0, 3'b000, 32'h10, 32'h0, 0, 32'hFFFFFFEF, 2, 1, 0, 32'h0);
      go(1, 3'b000, 32'h10, 32'h000000A5, 0, 32'h0, 3, 1, 1, 32'h1234BEA5);
      go(0, 3'b100, 32'h10, 32'h0, 0, 32'h000000A5, 2, 1, 0, 32'h0);

      // Illegal requests: one-cycle error, no strobes
      go(0, 3'b010, 32'h12, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0);
      go(1, 3'b001, 32'h11, 32'h5555, 1, 32'h0, 1, 0, 0, 32'h0);
      go(0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0);
      go(1, 3'b100, 32'h10, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0);
      go(0, 3'b111, 32'h10, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0);
      check("mem4_after_errors", mem[4], 32'h1234BEA5);

      // Upper address bits wrap onto word 6
      go(1, 3'b010, 32'h1000_0018, 32'h0BADF00D, 0, 32'h0, 2, 0, 1, 32'h0BADF00D);
      go(0, 3'b010, 32'h18, 32'h0, 0, 32'h0BADF00D, 2, 1, 0, 32'h0);

      // Back-to-back with req_valid held high
      issue(1, 3'b010, 32'h20, 32'hCAFE0001, 0, 32'h0, 2, 0, 1, 32'hCAFE0001, w1, a1);
      issue(0, 3'b010, 32'h20, 32'h0, 0, 32'hCAFE0001, 2, 1, 0, 32'h0, w2, a2);
      check("b2b_ready_low_cycles", 32'(w2), 32'd2);
      check("b2b_accept_gap", 32'(a2 - a1), 32'd3);
      drain();

      // Asynchronous reset in the middle of a WRITE cycle
      mem[5] = 32'h11112222;
      issue(1, 3'b010, 32'h14, 32'hCAFEF00D, 0, 32'h0, 2, 0, 1, 32'hCAFEF00D, w1, a1);
      req_valid = 1'b0;
      check("pre_reset_in_write", 32'(mem_write), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("reset_drops_write", 32'(mem_write), 32'd0);
      check("reset_ready", 32'(req_ready), 32'd1);
      exp_q.delete();
      rd_seen = 0;
      wr_seen = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_ready", 32'(req_ready), 32'd1);
      check("post_reset_resp_valid", 32'(resp_valid), 32'd0);
      check("mem5_unchanged", mem[5], 32'h11112222);
      go(0, 3'b010, 32'h14, 32'h0, 0, 32'h11112222, 2, 1, 0, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-only data memory interface (word index address, 32-bit write data, write/read strobes, asynchronous read data) on behalf of the core.
- Turns RISC-V byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Uses read-modify-write for sub-word stores, and extracts and extends sub-word loads.
- Sits between the core's execute/memory stage and the data memory.

Parameters:
- ADDR_W, 6, word-index width driven to memory; word index = req_addr[ADDR_W+1:2]; req_addr bits above ADDR_W+1 are ignored (wrap).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  valid only with resp_valid; misaligned or illegal request.
- mem_addr  out  ADDR_W  word index to data memory.
- mem_wdata  out  32  write data to data memory.
- mem_write  out  1  write strobe, sampled at the memory's rising edge.
- mem_read  out  1  read enable.
- mem_rdata  in  32  read data, combinational from mem_addr/mem_read.

Behaviour:
- Reset is asynchronous on rst_n low: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0, all captured request registers=0. After reset, req_ready=1.
- Reset mid-operation aborts the request with no further strobes. An RMW aborted before its WRITE cycle leaves memory unmodified.
- Accept: handshake on req_valid && req_ready at edge T. The block captures we, funct3, addr, wdata. Inputs are don't-care afterwards.
- Illegal requests:
  - funct3 in {011,110,111}, or store with funct3 100/101.
  - Misaligned: H with addr[0]=1, or W with addr[1:0]!=0.
  - Handling: T+1 is RESP with resp_err=1, resp_rdata=0, and no mem_read/mem_write ever asserted.
- States: IDLE, READ, WRITE, RESP.
  - IDLE -> READ: load, or SB/SH.
  - IDLE -> WRITE: SW.
  - IDLE -> RESP: error.
  - READ -> RESP: load.
  - READ -> WRITE: SB/SH.
  - WRITE -> RESP.
  - RESP -> IDLE unconditionally.
- READ: mem_read=1, mem_addr=word index. The block registers mem_rdata at the end of the cycle.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- WRITE: mem_write=1 for exactly one cycle.
  - mem_wdata = req_wdata for SW.
  - For SB/SH, mem_wdata = the captured word with the target lane replaced by wdata[7:0] or wdata[15:0]; all other bits are preserved.
- RESP: resp_valid=1 for one cycle with resp_err and resp_rdata. req_ready=0; a new request can be accepted the following cycle.
- Latency from accept edge to resp_valid cycle:
  - Load: 2 cycles (READ, RESP).
  - SW: 2 cycles (WRITE, RESP).
  - SB/SH: 3 cycles (READ, WRITE, RESP).
  - Error: 1 cycle.
- Invariants:
  - mem_read and mem_write are never high together.
  - Strobes are 0 in IDLE and RESP.
  - mem_addr holds the captured index from accept until return to IDLE.
  - resp_rdata holds its value until the next RESP.

Test Plan:
- Reset: rst_n low asynchronously mid-cycle in WRITE state -> mem_write drops immediately, state IDLE, req_ready=1 after release, target word unchanged.
- SW addr 0x0000_0010, wdata 0xDEADBEEF -> one mem_write at mem_addr=4, mem_wdata=0xDEADBEEF, resp_valid 2 cycles after accept, resp_err=0.
- Memory word 4 = 0xDEADBEEF:
  - LB addr 0x11 -> resp_rdata=0xFFFFFFBE.
  - LBU addr 0x11 -> 0x000000BE.
  - LH addr 0x12 -> 0xFFFFDEAD.
  - LHU addr 0x12 -> 0x0000DEAD.
  - Each has mem_read asserted for one cycle and resp_valid 2 cycles after accept.
- SB addr 0x13, wdata 0x12345677 on word 0xDEADBEEF -> READ then WRITE with mem_wdata=0x77ADBEEF, resp 3 cycles after accept; a following LW addr 0x10 returns 0x77ADBEEF.
- LW addr 0x12, and separately SH addr 0x11 -> resp_err=1 one cycle after accept, no mem strobes; funct3 011 load -> resp_err=1.
- Back-to-back: req_valid held high with a queued second request -> req_ready low from T+1 until return to IDLE; second accept occurs the cycle after resp_valid, never overlapping.
